// File: rtl/btb_pkg.sv
// Shared branch-prediction definitions: counter encodings, default geometry,
// and PC index/tag extraction reused by any predictor indexed like the BTB.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int BTB_ENTRIES_DEFAULT = 16;

    // Word-aligned PCs: bits [1:0] never participate in index or tag.
    function automatic logic [31:0] btb_index(input logic [31:0] addr, input int idx_w);
        return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] btb_tag(input logic [31:0] addr, input int idx_w);
        return addr >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and execute-training signals of the BTB.
// BTB_STATS_EN adds the pc_en_i qualifier and the statistics outputs.
interface btb_if;
    logic        pc;
    logic [31:0] pc_addr;
    logic        btb_pc_valid;
    logic        btb_pc_predictTaken;
    logic [31:0] btb_target_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush_all;
`ifdef BTB_STATS_EN
    logic        pc_en_i;
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;
`endif

    modport master (
        output pc_addr, upd_en, upd_pc, upd_is_branch, upd_taken, upd_target, flush_all,
`ifdef BTB_STATS_EN
        output pc_en_i,
        input  stat_lookups, stat_hits, stat_mispredicts,
`endif
        input  btb_pc_valid, btb_pc_predictTaken, btb_target_pc
    );

    modport slave (
        input  pc_addr, upd_en, upd_pc, upd_is_branch, upd_taken, upd_target, flush_all,
`ifdef BTB_STATS_EN
        input  pc_en_i,
        output stat_lookups, stat_hits, stat_mispredicts,
`endif
        output btb_pc_valid, btb_pc_predictTaken, btb_target_pc
    );
endinterface

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating direction counter.
module sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] nxt
);
    always_comb begin
        // NOTE: combinational logic uses blocking '='; registers use '<=' so every flop samples pre-edge values.
        nxt = cnt;
        if (inc) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup on the fetch PC, trained at the clock edge.
// Define BTB_STATS_EN to add saturating lookup/hit/mispredict statistics counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int         ENTRIES  = BTB_ENTRIES_DEFAULT,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CTR_INIT = WT
) (
    input logic  clk,
    input logic  rst,
    btb_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid      [ENTRIES];
    logic [1:0]       ctr        [ENTRIES];
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    logic [31:0]      target_mem [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic [1:0]       ctr_next;
    logic             do_alloc, do_train, do_inval;

    assign l_idx = IDX_W'(btb_index(bus.pc_addr, IDX_W));
    assign l_tag = TAG_W'(btb_tag(bus.pc_addr, IDX_W));
    assign u_idx = IDX_W'(btb_index(bus.upd_pc, IDX_W));
    assign u_tag = TAG_W'(btb_tag(bus.upd_pc, IDX_W));

    // Lookup reads the registered arrays only, so same-cycle updates are not visible.
    always_comb begin
        l_hit                   = valid[l_idx] && (tag_mem[l_idx] == l_tag);
        bus.btb_pc_valid        = l_hit;
        bus.btb_pc_predictTaken = l_hit && ctr[l_idx][1];
        bus.btb_target_pc       = l_hit ? target_mem[l_idx] : 32'd0;
    end

    assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

    sat_counter2 u_ctr (
        .cnt (ctr[u_idx]),
        .inc (bus.upd_taken),
        .nxt (ctr_next)
    );

    // flush_all suppresses the whole update, including target/tag writes.
    always_comb begin
        do_alloc = 1'b0;
        do_train = 1'b0;
        do_inval = 1'b0;
        if (bus.upd_en && !bus.flush_all) begin
            if (u_hit) begin
                if (bus.upd_is_branch) do_train = 1'b1;
                else                   do_inval = 1'b1;
            end else if (bus.upd_is_branch && bus.upd_taken) begin
                do_alloc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_INIT;
            end
        end else if (bus.flush_all) begin
            for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
        end else if (do_alloc) begin
            valid[u_idx] <= 1'b1;
            ctr[u_idx]   <= CTR_INIT;
        end else if (do_train) begin
            ctr[u_idx]   <= ctr_next;
        end else if (do_inval) begin
            valid[u_idx] <= 1'b0;
        end
    end

    // NOTE: tag/target arrays are deliberately unreset; valid=0 masks their contents.
    always_ff @(posedge clk) begin
        if (do_alloc || (do_train && bus.upd_taken))
            target_mem[u_idx] <= {bus.upd_target[31:2], 2'b00};
        if (do_alloc)
            tag_mem[u_idx] <= u_tag;
    end

`ifdef BTB_STATS_EN
    logic mispredict;
    assign mispredict = bus.upd_en && u_hit && (ctr[u_idx][1] != bus.upd_taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.stat_lookups     <= '0;
            bus.stat_hits        <= '0;
            bus.stat_mispredicts <= '0;
        end else begin
            if (bus.pc_en_i && bus.stat_lookups != '1)
                bus.stat_lookups <= bus.stat_lookups + 32'd1;
            if (bus.pc_en_i && l_hit && bus.stat_hits != '1)
                bus.stat_hits <= bus.stat_hits + 32'd1;
            if (mispredict && bus.stat_mispredicts != '1)
                bus.stat_mispredicts <= bus.stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus random
// training traffic compared against an array-based model of the prediction rules.
module tb_branch_target_buffer;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    btb_if bus ();

    branch_target_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 16 entries, index = (pc/4)%16, tag = pc/64.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2;
        end
    endfunction

    function automatic logic [33:0] model_lookup(input logic [31:0] a);
        int i;
        i = int'((a / 4) % 16);
        if (m_valid[i] && m_tag[i] == a / 64)
            return {1'b1, (m_ctr[i] >= 2) ? 1'b1 : 1'b0, m_tgt[i]};
        return 34'd0;
    endfunction

    function automatic void model_update(input logic [31:0] a, input logic br, input logic tk,
                                         input logic [31:0] tgt, input logic fl);
        int i;
        if (fl) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
            return;
        end
        i = int'((a / 4) % 16);
        if (m_valid[i] && m_tag[i] == a / 64) begin
            if (!br) m_valid[i] = 1'b0;
            else if (tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt & ~32'd3;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (br && tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = a / 64;
            m_tgt[i]   = tgt & ~32'd3;
            m_ctr[i]   = 2;
        end
    endfunction

    // One update cycle (stimulus + model advance); the update lands at the posedge.
    task automatic do_update(input logic [31:0] a, input logic br, input logic tk,
                             input logic [31:0] tgt, input logic fl);
        @(negedge clk);
        bus.upd_en        = 1'b1;
        bus.upd_pc        = a;
        bus.upd_is_branch = br;
        bus.upd_taken     = tk;
        bus.upd_target    = tgt;
        bus.flush_all     = fl;
        @(posedge clk);
        if (rst) model_update(a, br, tk, tgt, fl);
        #1;
        bus.upd_en    = 1'b0;
        bus.flush_all = 1'b0;
    endtask

    function automatic logic [33:0] observed();
        return {bus.btb_pc_valid, bus.btb_pc_predictTaken, bus.btb_target_pc};
    endfunction

    task automatic test_reset();
        logic [33:0] obs;
        rst = 1'b0;
        bus.pc_addr = 32'h0000_0040;
        bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_is_branch = 1'b0;
        bus.upd_taken = 1'b0; bus.upd_target = '0; bus.flush_all = 1'b0;
`ifdef BTB_STATS_EN
        bus.pc_en_i = 1'b1;
`endif
        model_reset();
        #3;
        obs = observed();
        checks++;
        if (obs !== 34'd0) begin
            $display("FAIL reset_in: got %h expected %h", obs, 34'd0);
            failures++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        obs = observed();
        checks++;
        if (obs !== 34'd0) begin
            $display("FAIL reset_after: got %h expected %h", obs, 34'd0);
            failures++;
        end
    endtask

    task automatic test_allocate();
        logic [31:0] pcs [2] = '{32'h40, 32'h42};
        logic [33:0] obs;
        do_update(32'h40, 1'b1, 1'b1, 32'h100, 1'b0);
        foreach (pcs[k]) begin
            @(negedge clk);
            bus.pc_addr = pcs[k];
            #1;
            obs = observed();
            checks++;
            if (obs !== {1'b1, 1'b1, 32'h100}) begin
                $display("FAIL alloc_%h: got %h expected %h", pcs[k], obs, {1'b1, 1'b1, 32'h100});
                failures++;
            end
        end
    endtask

    task automatic test_saturate();
        // Directions and the prediction expected after each one, starting from ctr=10.
        logic       dir  [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
        logic       pred [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [33:0] obs;
        bus.pc_addr = 32'h40;
        foreach (dir[k]) begin
            do_update(32'h40, 1'b1, dir[k], 32'h100, 1'b0);
            #1;
            obs = observed();
            checks++;
            if (obs !== {1'b1, pred[k], 32'h100} || obs !== model_lookup(32'h40)) begin
                $display("FAIL saturate_%0d: got %h expected %h", k, obs, {1'b1, pred[k], 32'h100});
                failures++;
            end
        end
    endtask

    task automatic test_alias();
        logic [31:0] pcs [3] = '{32'h40, 32'h440, 32'h840};
        logic [33:0] obs, exp;
        do_update(32'h440, 1'b1, 1'b1, 32'h300, 1'b0);
        do_update(32'h840, 1'b1, 1'b0, 32'h500, 1'b0);
        foreach (pcs[k]) begin
            @(negedge clk);
            bus.pc_addr = pcs[k];
            #1;
            obs = observed();
            exp = (k == 1) ? {1'b1, 1'b1, 32'h300} : 34'd0;
            checks++;
            if (obs !== exp) begin
                $display("FAIL alias_%h: got %h expected %h", pcs[k], obs, exp);
                failures++;
            end
        end
        do_update(32'h440, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        obs = observed();
        checks++;
        if (obs !== 34'd0) begin
            $display("FAIL alias_nonbranch_inval: got %h expected %h", obs, 34'd0);
            failures++;
        end
    endtask

    task automatic test_same_cycle_and_flush();
        logic [31:0] pcs [3] = '{32'h80, 32'h90, 32'hC0};
        logic [33:0] obs;
        @(negedge clk);
        bus.pc_addr = 32'h80;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h80; bus.upd_is_branch = 1'b1;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h180; bus.flush_all = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== 34'd0) begin
            $display("FAIL same_cycle_pre: got %h expected %h", obs, 34'd0);
            failures++;
        end
        @(posedge clk);
        model_update(32'h80, 1'b1, 1'b1, 32'h180, 1'b0);
        #1;
        bus.upd_en = 1'b0;
        obs = observed();
        checks++;
        if (obs !== {1'b1, 1'b1, 32'h180}) begin
            $display("FAIL same_cycle_post: got %h expected %h", obs, {1'b1, 1'b1, 32'h180});
            failures++;
        end
        do_update(32'h90, 1'b1, 1'b1, 32'h190, 1'b0);
        do_update(32'hC0, 1'b1, 1'b1, 32'h1C0, 1'b1);
        foreach (pcs[k]) begin
            @(negedge clk);
            bus.pc_addr = pcs[k];
            #1;
            obs = observed();
            checks++;
            if (obs !== 34'd0) begin
                $display("FAIL flush_%h: got %h expected %h", pcs[k], obs, 34'd0);
                failures++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, q, tgt;
        logic        br, tk, fl;
        logic [33:0] obs, exp;
        for (int n = 0; n < 300; n++) begin
            a   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            br  = ($urandom_range(0, 7) != 0);
            tk  = $urandom_range(0, 1);
            fl  = ($urandom_range(0, 31) == 0);
            tgt = $urandom;
            do_update(a, br, tk, tgt, fl);
            q = ($urandom_range(0, 1) != 0) ? a
                : (($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            @(negedge clk);
            bus.pc_addr = q;
            #1;
            obs = observed();
            exp = model_lookup(q);
            checks++;
            if (obs !== exp) begin
                $display("FAIL random_%0d pc=%h: got %h expected %h", n, q, obs, exp);
                failures++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [33:0] obs;
        do_update(32'h40, 1'b1, 1'b1, 32'h100, 1'b0);
        @(negedge clk);
        bus.pc_addr = 32'h40;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        obs = observed();
        checks++;
        if (obs !== 34'd0) begin
            $display("FAIL async_reset: got %h expected %h", obs, 34'd0);
            failures++;
        end
`ifdef BTB_STATS_EN
        checks++;
        if ({bus.stat_lookups, bus.stat_hits, bus.stat_mispredicts} !== 96'd0) begin
            $display("FAIL async_reset_stats: got %h %h %h expected 0",
                     bus.stat_lookups, bus.stat_hits, bus.stat_mispredicts);
            failures++;
        end
`endif
        // An allocation presented while reset is held must be lost.
        do_update(32'h40, 1'b1, 1'b1, 32'h200, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs = observed();
        checks++;
        if (obs !== 34'd0) begin
            $display("FAIL reset_wins_update: got %h expected %h", obs, 34'd0);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturate();
        test_alias();
        test_same_cycle_and_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer. It is the prediction source that drives fetch_stage's btb_pc_valid / btb_pc_predictTaken / btb_target_pc inputs.
- Lookup is combinational on the current fetch PC.
- Training is sequential, driven by branch resolution from the execute stage.
- Each entry holds tag, target and a 2-bit saturating direction counter.

Parameters:
- ENTRIES, 16, number of entries; power of two, minimum 4.
- IDX_W, $clog2(ENTRIES), index width; derived, do not override.
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  32  current fetch PC (lookup address).
- btb_pc_valid  out  1  lookup hit: entry valid and tag matches.
- btb_pc_predictTaken  out  1  hit && counter[1].
- btb_target_pc  out  32  stored target on hit; 32'd0 on miss.
- upd_en  in  1  execute stage resolved a control-flow instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_is_branch  in  1  resolved instruction is a branch/jump.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target address.
- flush_all  in  1  synchronous invalidate of all entries (fence.i / context change).

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored. upd_pc is split identically.
- Storage: valid[ENTRIES], tag[ENTRIES], target[ENTRIES] (bits [1:0] stored as 0), ctr[ENTRIES] (2-bit).
- Reset (rst=0, asynchronous): all valid=0 and all ctr=CTR_INIT. Tag and target need no reset. All outputs read 0 while in reset and after it until the first allocation.
- Lookup: purely combinational from the registered arrays, zero-cycle latency, so fetch can select the next PC in the same cycle.
- Update: takes effect at the rising edge when upd_en=1. Classify the entry at the update index as hit (valid and tag match) or miss.
  - hit, upd_is_branch=1: ctr saturating +1 if taken, else -1. Floor 2'b00, ceiling 2'b11, no wrap. If taken, target is overwritten with upd_target.
  - hit, upd_is_branch=0: aliasing / self-modified code; clear valid.
  - miss, upd_is_branch=1, upd_taken=1: allocate, overwriting any occupant. valid=1, tag written, target=upd_target, ctr=CTR_INIT.
  - miss, not taken, or not a branch: no state change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no write-to-read bypass.
- flush_all: clears every valid bit at the edge and has priority over a simultaneous upd_en. Counters are retained.
- Reset asserted mid-update: the reset wins and the update is lost.
- Outputs are stable with pc. No handshake; the block never stalls fetch.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds outputs stat_lookups[31:0], stat_hits[31:0], stat_mispredicts[31:0].
  - lookups increments every cycle with pc_en_i=1, a new 1-bit input present only under the macro.
  - hits increments when pc_en_i && btb_pc_valid.
  - mispredicts increments on an update hit whose pre-update ctr[1] != upd_taken.
  - All three saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by flush_all.
- Undefined: these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package btb_pkg holds:
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - The default ENTRIES.
  - Index/tag extraction functions, shared with any future branch predictor.
- Sub-module sat_counter2: 2-bit saturating up/down next-state logic, instantiated per update path (not per entry).

Test Plan:
- Reset: rst=0 then 1, pc=32'h0000_0040 -> btb_pc_valid=0, btb_pc_predictTaken=0, btb_target_pc=0.
- Allocate: update upd_pc=32'h40, taken, target=32'h100. Next cycle pc=32'h40 -> valid=1, predictTaken=1 (ctr 10), target=32'h100. pc=32'h42 also hits.
- Saturate: three more taken updates -> ctr=11. Then two not-taken -> ctr=01, predictTaken=0, valid=1. Two more not-taken -> ctr=00, with no wrap to 11.
- Alias: with ENTRIES=16, taken update at 32'h40 then taken update at 32'h440 (same index) -> pc=32'h40 misses and pc=32'h440 hits with the new target. A not-taken miss at 32'h840 leaves the entry unchanged.
- Same-cycle read/write and flush: lookup pc=32'h40 in the same cycle as its allocating update -> valid=0 that cycle, 1 the next. flush_all together with upd_en -> all entries invalid afterward.
- Async reset mid-run: drop rst between clock edges after allocations -> outputs go to 0 immediately. With BTB_STATS_EN defined, counters read 0.
